// File: rtl/muldiv_unit_if.sv
// Handshake and result bus between the EX-stage pipeline control and the
// iterative multiply/divide unit.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide producing HI/LO, one bit per cycle,
// with architectural HI/LO registers writable through MTHI/MTLO.
module muldiv_unit (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;
  logic [31:0] r_opnd;
  logic [63:0] r_acc;
  logic [32:0] r_rem;

  logic        w_accept;
  logic        w_fix;
  logic        w_mt_ok;
  logic        w_is_signed;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_sum;
  logic [33:0] w_shift;
  logic [33:0] w_diff;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem_fix;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_fix    = 1'b0;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          w_next   = S_CALC;
          w_accept = 1'b1;
        end
        S_CALC: if (r_cnt == 6'd1) w_next = S_FIX;
        S_FIX: begin
          w_next = S_IDLE;
          w_fix  = 1'b1;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_mt_ok     = (r_state == S_IDLE) && !bus.start && !bus.flush;
  assign w_is_signed = ~bus.op[0];
  assign w_mag_a     = (w_is_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign w_mag_b     = (w_is_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit (LSB of the accumulator) is set, then shift right.
  assign w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
  assign w_shift = {r_rem, r_acc[31]};
  assign w_diff  = w_shift - {2'b00, r_opnd};

  assign w_prod    = r_neg_q ? (64'd0 - r_acc) : r_acc;
  assign w_quo     = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem_fix = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
  // Divide by zero leaves remainder = |a|; re-applying the dividend sign restores a exactly.
  assign w_res_lo  = r_is_div ? (r_dz ? 32'hFFFF_FFFF : w_quo) : w_prod[31:0];
  assign w_res_hi  = r_is_div ? w_rem_fix : w_prod[63:32];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_opnd   <= 32'd0;
      r_acc    <= 64'd0;
      r_rem    <= 33'd0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= w_fix;

      if (w_accept) begin
        r_is_div <= bus.op[1];
        r_neg_q  <= w_is_signed & (bus.a[31] ^ bus.b[31]);
        r_neg_r  <= w_is_signed & bus.op[1] & bus.a[31];
        r_dz     <= (bus.b == 32'd0);
        r_cnt    <= 6'd32;
        r_rem    <= 33'd0;
        if (bus.op[1]) begin
          r_opnd <= w_mag_b;
          r_acc  <= {32'd0, w_mag_a};
        end else begin
          r_opnd <= w_mag_a;
          r_acc  <= {32'd0, w_mag_b};
        end
      end else if (r_state == S_CALC && !bus.flush) begin
        r_cnt <= r_cnt - 6'd1;
        if (r_is_div) begin
          if (!w_diff[33]) begin
            r_rem        <= w_diff[32:0];
            r_acc[31:0]  <= {r_acc[30:0], 1'b1};
          end else begin
            r_rem        <= w_shift[32:0];
            r_acc[31:0]  <= {r_acc[30:0], 1'b0};
          end
        end else begin
          r_acc <= {w_sum, r_acc[31:1]};
        end
      end

      if (w_fix) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mt_ok) begin
        if (bus.mthi) r_hi <= bus.wdata;
        if (bus.mtlo) r_lo <= bus.wdata;
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit that produces the HI/LO pair for MULT, MULTU, DIV and DIVU and holds it in architectural HI/LO registers. It sits beside the single-cycle ALU in the EX stage. It takes the same 32-bit operands and replaces the ALU's combinational product/quotient path with an iterative engine: one bit per cycle, with a start/busy/done handshake. The pipeline control stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO. MTHI/MTLO write the registers directly.

## Interface
Parameters:
- none (datapath fixed at 32 bits, 32 iterations)

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `start`  in  1  Launches the operation in `op` with `a`, `b`; sampled only when idle.
- `op`  in  2  Operation select: 0 = MULT (signed), 1 = MULTU, 2 = DIV (signed), 3 = DIVU.
- `a`  in  32  Multiplicand or dividend.
- `b`  in  32  Multiplier or divisor.
- `mthi`  in  1  Write `wdata` to HI; honoured only when idle and `start`=0.
- `mtlo`  in  1  Write `wdata` to LO; same qualification as `mthi`.
- `wdata`  in  32  Data for MTHI/MTLO.
- `flush`  in  1  Abort the in-flight operation (exception or branch flush).
- `busy`  out  1  High while an operation is in flight.
- `done`  out  1  One-cycle pulse; HI/LO hold the new result in that cycle.
- `hi`  out  32  HI register: product[63:32] or remainder.
- `lo`  out  32  LO register: product[31:0] or quotient.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start`=1:
  - Latch the operand magnitudes; signed ops take the absolute value via two's complement.
  - Latch the result signs:
    - Product sign = a[31]^b[31] (signed MULT).
    - Quotient sign = a[31]^b[31]; remainder sign = a[31] (signed DIV).
  - Latch the divide-by-zero flag (`b`==0).
  - Load the iteration counter with 32; go to CALC.
- CALC, multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first, with a 33-bit partial remainder.
- CALC: decrement the counter each cycle; after the 32nd iteration, go to FIX.
- FIX: apply sign correction (negate the 64-bit product or the quotient/remainder as latched), write `hi`/`lo`, pulse `done`, go to IDLE.
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = `a` (original operand, unmodified), regardless of sign.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (two's-complement wrap, no trap).
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- `start` while busy: ignored; operands are not relatched.
- `mthi`/`mtlo` while busy or with `start`=1: ignored. Both asserted together while idle: both written.
- `flush`:
  - From any state, return to IDLE on the next edge.
  - `hi`/`lo` unchanged, no `done`.
  - `flush` takes priority over `start` and over `mthi`/`mtlo` in the same cycle.
- `rst` (async): state IDLE, counter 0, `busy`=0, `done`=0, `hi`=0, `lo`=0, internal accumulators 0. A reset mid-operation discards the operation.

## Timing
- `start` sampled at edge E0 → `busy`=1 from E0 until E33.
- Edges E1–E32 perform the 32 iterations; at E33, FIX writes `hi`/`lo`.
- After E33: `done`=1 for exactly one cycle and `busy`=0. Total latency: 33 cycles start-to-result.
- `busy` is a registered function of state (≠IDLE); it never depends combinationally on `start`.
- A new `start` is accepted in the same cycle `done` is high; `busy` stays 0 only if no start occurs.
- MTHI/MTLO: `hi`/`lo` update at the edge the write is sampled; visible the next cycle.
- `hi`/`lo` never change during CALC; intermediate values stay internal.
- `flush` sampled at edge Ef → `busy`=0 after Ef.

## Test plan
- Reset, then MULT a=0xFFFFFFFF, b=2:
  - `busy` high 33 cycles, `done` pulse once.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Same operands with MULTU → HI=0x00000001, LO=0xFFFFFFFE.
- Divide signs:
  - DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU a=7, b=2 → LO=3, HI=1.
  - DIV a=7, b=0xFFFFFFFE → LO=0xFFFFFFFD, HI=1.
- Corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU a=5, b=0 → LO=0xFFFFFFFF, HI=5.
  - DIV a=0xFFFFFFFB, b=0 → LO=0xFFFFFFFF, HI=0xFFFFFFFB.
- Start/flush handling:
  - Start MULTU 3×4; re-assert `start` with 9×9 at cycle 5 → result HI=0, LO=12, single `done`.
  - Flush at cycle 10 of a DIVU → `busy`=0 next cycle, no `done`, HI/LO keep prior values.
- Register writes:
  - Idle: `mthi`=1, `mtlo`=1, `wdata`=0x1234 → HI=LO=0x1234 next cycle.
  - Same cycle as `start` → write ignored.
  - Assert `rst` asynchronously mid-CALC → `busy`, `done`, HI, LO all 0 immediately, no `done` afterwards.
- Back-to-back: issue a new `start` in the `done` cycle → second result exactly 33 cycles later, first result visible in between.
